// File: rtl/io_port_bridge_pkg.sv
// Package iob_pkg: shared width helpers for the I/O port bridge.
// A FIFO entry is packed as {ts, addr, data}; data sits in the low bits,
// the port address above it and, when IOB_TSTAMP_EN is defined, the
// cycle stamp on top.
package iob_pkg;

    // Data word width from the mantissa/exponent split (plus sign bit).
    function automatic int iob_data_w(input int nbmant, input int nbexpo);
        return nbmant + nbexpo + 1;
    endfunction

    // Bit offset of the port address field inside a FIFO entry.
    function automatic int iob_addr_lsb(input int w);
        return w;
    endfunction

    // Bit offset of the timestamp field inside a FIFO entry.
    function automatic int iob_ts_lsb(input int w, input int aow);
        return w + aow;
    endfunction

    // Total FIFO entry width; pass tsw=0 when timestamps are disabled.
    function automatic int iob_entry_w(input int w, input int aow, input int tsw);
        return w + aow + tsw;
    endfunction

endpackage

// File: rtl/io_port_bridge_fifo.sv
// io_fifo: first-word-fall-through FIFO, depth 2**DEPW, registered storage.
// A push into a full FIFO is accepted only when a pop frees the head slot
// in the same cycle; a pop on an empty FIFO is ignored.
module io_fifo #(
    parameter int WIDTH = 26,
    parameter int DEPW  = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int DEPTH = 1 << DEPW;
    localparam logic [DEPW:0] FULL_CNT = (DEPW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [DEPW-1:0]  wr_ptr_r;
    logic [DEPW-1:0]  rd_ptr_r;
    logic [DEPW:0]    count_r;
    logic             pop_ok_s;
    logic             push_ok_s;

    // Qualify push/pop against the current occupancy.
    always_comb begin
        pop_ok_s  = pop & (count_r != {(DEPW+1){1'b0}});
        push_ok_s = push & ((count_r != FULL_CNT) | pop_ok_s);
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo depth.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= {DEPW{1'b0}};
            rd_ptr_r <= {DEPW{1'b0}};
            count_r  <= {(DEPW+1){1'b0}};
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + DEPW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + DEPW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (DEPW+1)'(1);
                2'b01:   count_r <= count_r - (DEPW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage; cleared on reset so no stale entry can leak out.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_r[i] <= {WIDTH{1'b0}};
        end else if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_ptr_r];
    assign full    = (count_r == FULL_CNT);
    assign empty   = (count_r == {(DEPW+1){1'b0}});

endmodule

// File: rtl/io_port_bridge.sv
// io_port_bridge: peripheral side of the core I/O port protocol.
// Input ports: one holding register per port, loaded over valid/ready,
// consumed by core reads (zero-latency combinational read data).
// Output ports: core writes queued as {addr,data} in io_fifo and drained
// by a single valid/ready consumer.
// Optional macro IOB_TSTAMP_EN adds a free-running cycle stamp per entry
// and the snk_ts port.
module io_port_bridge
    import iob_pkg::*;
#(
    parameter int NBMANT = 16,
    parameter int NBEXPO = 6,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int OFDEPW = 3,
`ifdef IOB_TSTAMP_EN
    parameter int TSW    = 16,
`endif
    localparam int W   = iob_data_w(NBMANT, NBEXPO),
    localparam int AIW = $clog2(NUIOIN),
    localparam int AOW = $clog2(NUIOOU)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_in,
    input  logic [AIW-1:0]      addr_in,
    output logic [W-1:0]        io_in,
    input  logic                out_en,
    input  logic [AOW-1:0]      addr_out,
    input  logic [W-1:0]        data_out,
    input  logic [NUIOIN-1:0]   src_valid,
    input  logic [NUIOIN*W-1:0] src_data,
    output logic [NUIOIN-1:0]   src_ready,
    output logic                snk_valid,
    output logic [AOW-1:0]      snk_addr,
    output logic [W-1:0]        snk_data,
`ifdef IOB_TSTAMP_EN
    output logic [TSW-1:0]      snk_ts,
`endif
    input  logic                snk_ready,
    output logic                underrun,
    output logic                overflow,
    input  logic                flags_clr
);
    localparam int ADDR_LSB = iob_addr_lsb(W);
`ifdef IOB_TSTAMP_EN
    localparam int TS_LSB   = iob_ts_lsb(W, AOW);
    localparam int ENT_W    = iob_entry_w(W, AOW, TSW);
`else
    localparam int ENT_W    = iob_entry_w(W, AOW, 0);
`endif

    logic [W-1:0]      hold_r [NUIOIN];
    logic [NUIOIN-1:0] hold_v_r;
    logic [NUIOIN-1:0] load_s;
    logic [NUIOIN-1:0] clr_s;
    logic              rd_in_range_s;
    logic              rd_hit_s;
    logic              underrun_set_s;
    logic              wr_in_range_s;
    logic              overflow_set_s;
    logic              pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [ENT_W-1:0]  wr_entry_s;
    logic [ENT_W-1:0]  rd_entry_s;
    logic              underrun_r;
    logic              overflow_r;

    // Core read path: zero-latency read of the addressed holding register.
    always_comb begin
        rd_in_range_s = (int'(addr_in) < NUIOIN);
        if (rd_in_range_s) begin
            io_in    = hold_r[addr_in];
            rd_hit_s = hold_v_r[addr_in];
        end else begin
            io_in    = {W{1'b0}};
            rd_hit_s = 1'b0;
        end
        underrun_set_s = req_in & ~rd_hit_s;
    end

    // Per-port load/consume strobes; a port never loads and clears at once.
    always_comb begin
        load_s = {NUIOIN{1'b0}};
        clr_s  = {NUIOIN{1'b0}};
        for (int k = 0; k < NUIOIN; k++) begin
            load_s[k] = src_valid[k] & ~hold_v_r[k];
            clr_s[k]  = req_in & rd_hit_s & (int'(addr_in) == k);
        end
    end

    // Holding registers and their valid bits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_v_r <= {NUIOIN{1'b0}};
            for (int k = 0; k < NUIOIN; k++) hold_r[k] <= {W{1'b0}};
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (load_s[k]) begin
                    hold_r[k]   <= src_data[k*W +: W];
                    hold_v_r[k] <= 1'b1;
                end else if (clr_s[k]) begin
                    hold_v_r[k] <= 1'b0;
                end
            end
        end
    end

    assign src_ready = ~hold_v_r;

    // Write qualification: out-of-range ports are dropped silently, a full
    // FIFO without a concurrent pop drops the write and flags overflow.
    always_comb begin
        wr_in_range_s  = out_en & (int'(addr_out) < NUIOOU);
        pop_s          = ~fifo_empty_s & snk_ready;
        overflow_set_s = wr_in_range_s & fifo_full_s & ~pop_s;
    end

`ifdef IOB_TSTAMP_EN
    logic [TSW-1:0] ts_r;

    // Free-running cycle stamp captured with every push.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ts_r <= {TSW{1'b0}};
        else      ts_r <= ts_r + TSW'(1);
    end

    assign wr_entry_s = {ts_r, addr_out, data_out};
    assign snk_ts     = rd_entry_s[TS_LSB +: TSW];
`else
    assign wr_entry_s = {addr_out, data_out};
`endif

    io_fifo #(
        .WIDTH (ENT_W),
        .DEPW  (OFDEPW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_in_range_s),
        .wr_data (wr_entry_s),
        .pop     (pop_s),
        .rd_data (rd_entry_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    assign snk_valid = ~fifo_empty_s;
    assign snk_addr  = rd_entry_s[ADDR_LSB +: AOW];
    assign snk_data  = rd_entry_s[W-1:0];

    // Sticky error flags; a clear wins over a set in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            underrun_r <= 1'b0;
            overflow_r <= 1'b0;
        end else if (flags_clr) begin
            underrun_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (underrun_set_s) underrun_r <= 1'b1;
            if (overflow_set_s) overflow_r <= 1'b1;
        end
    end

    assign underrun = underrun_r;
    assign overflow = overflow_r;

endmodule

// File: tb/tb_io_port_bridge.sv
// Testbench for io_port_bridge: directed scenarios plus randomized traffic,
// every output compared against a queue/array reference model each cycle.
module tb_io_port_bridge;
    localparam int W     = 23;
    localparam int NIN   = 8;
    localparam int DEPTH = 8;

    logic              clk;
    logic              rst;
    logic              req_in;
    logic [2:0]        addr_in;
    logic [W-1:0]      io_in;
    logic              out_en;
    logic [2:0]        addr_out;
    logic [W-1:0]      data_out;
    logic [NIN-1:0]    src_valid;
    logic [NIN*W-1:0]  src_data;
    logic [NIN-1:0]    src_ready;
    logic              snk_valid;
    logic [2:0]        snk_addr;
    logic [W-1:0]      snk_data;
`ifdef IOB_TSTAMP_EN
    logic [15:0]       snk_ts;
`endif
    logic              snk_ready;
    logic              underrun;
    logic              overflow;
    logic              flags_clr;

    io_port_bridge dut (
        .clk       (clk),
        .rst       (rst),
        .req_in    (req_in),
        .addr_in   (addr_in),
        .io_in     (io_in),
        .out_en    (out_en),
        .addr_out  (addr_out),
        .data_out  (data_out),
        .src_valid (src_valid),
        .src_data  (src_data),
        .src_ready (src_ready),
        .snk_valid (snk_valid),
        .snk_addr  (snk_addr),
        .snk_data  (snk_data),
`ifdef IOB_TSTAMP_EN
        .snk_ts    (snk_ts),
`endif
        .snk_ready (snk_ready),
        .underrun  (underrun),
        .overflow  (overflow),
        .flags_clr (flags_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    typedef struct {
        logic [2:0]   a;
        logic [W-1:0] d;
        logic [15:0]  t;
    } ent_t;

    logic [W-1:0]   m_hold [NIN];
    logic [NIN-1:0] m_hv;
    ent_t           m_q [$];
    logic           m_und;
    logic           m_ovf;
    logic [15:0]    m_ts;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NIN; k++) m_hold[k] = '0;
        m_hv  = '0;
        m_q.delete();
        m_und = 1'b0;
        m_ovf = 1'b0;
        m_ts  = 16'd0;
    endtask

    // Compare every visible output against the model (inputs already stable).
    task automatic check_outputs();
        logic [NIN-1:0] exp_rdy;
        exp_rdy = ~m_hv;
        check("io_in", io_in, m_hold[addr_in]);
        check("src_ready", src_ready, exp_rdy);
        check("snk_valid", snk_valid, m_q.size() > 0);
        if (m_q.size() > 0) begin
            check("snk_addr", snk_addr, m_q[0].a);
            check("snk_data", snk_data, m_q[0].d);
`ifdef IOB_TSTAMP_EN
            check("snk_ts", snk_ts, m_q[0].t);
`endif
        end
        check("underrun", underrun, m_und);
        check("overflow", overflow, m_ovf);
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_step();
        int             sz;
        bit             pop;
        bit             set_und;
        bit             set_ovf;
        logic [NIN-1:0] nhv;
        ent_t           e;
        sz      = m_q.size();
        pop     = (sz > 0) && snk_ready;
        set_und = 1'b0;
        set_ovf = 1'b0;
        nhv     = m_hv;
        if (req_in) begin
            if (m_hv[addr_in]) nhv[addr_in] = 1'b0;
            else               set_und = 1'b1;
        end
        for (int k = 0; k < NIN; k++) begin
            if (src_valid[k] && !m_hv[k]) begin
                m_hold[k] = src_data[k*W +: W];
                nhv[k]    = 1'b1;
            end
        end
        m_hv = nhv;
        if (pop) void'(m_q.pop_front());
        if (out_en) begin
            if (sz - int'(pop) < DEPTH) begin
                e.a = addr_out;
                e.d = data_out;
                e.t = m_ts;
                m_q.push_back(e);
            end else begin
                set_ovf = 1'b1;
            end
        end
        if (flags_clr) begin
            m_und = 1'b0;
            m_ovf = 1'b0;
        end else begin
            if (set_und) m_und = 1'b1;
            if (set_ovf) m_ovf = 1'b1;
        end
        m_ts = m_ts + 16'd1;
    endtask

    // One clock: check just before the rising edge, update model, go to negedge.
    task automatic cycle();
        #3;
        check_outputs();
        model_step();
        @(negedge clk);
    endtask

    task automatic idle();
        req_in    = 1'b0;
        addr_in   = 3'd0;
        out_en    = 1'b0;
        addr_out  = 3'd0;
        data_out  = '0;
        src_valid = '0;
        src_data  = '0;
        snk_ready = 1'b0;
        flags_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [2:0]   wa [9];
    logic [W-1:0] wd [9];
    logic [W-1:0] new_d;
    logic [15:0]  t1;
    logic [15:0]  t2;

    initial begin
        idle();
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 1: reset mid-stream with three words queued and flags set
        for (int i = 0; i < 3; i++) begin
            out_en   = 1'b1;
            addr_out = 3'(i + 1);
            data_out = W'($urandom);
            src_valid = 8'h01;
            src_data[W-1:0] = W'($urandom);
            cycle();
        end
        idle();
        req_in  = 1'b1;
        addr_in = 3'd6;
        cycle();
        idle();
        check("t1_pre_valid", snk_valid, 1'b1);
        do_reset();
        check("t1_snk_valid", snk_valid, 1'b0);
        check("t1_src_ready", src_ready, 8'hFF);
        check("t1_underrun", underrun, 1'b0);
        check("t1_overflow", overflow, 1'b0);
        check("t1_io_in", io_in, 23'd0);
        cycle();

        // 2: producer port 3 then zero-latency core read
        src_valid = 8'h08;
        src_data[3*W +: W] = 23'h12345;
        cycle();
        idle();
        check("t2_src_ready_busy", src_ready[3], 1'b0);
        req_in  = 1'b1;
        addr_in = 3'd3;
        #1;
        check("t2_io_in", io_in, 23'h12345);
        cycle();
        idle();
        check("t2_src_ready_back", src_ready[3], 1'b1);
        check("t2_underrun", underrun, 1'b0);

        // 3: read of an empty port, then clear
        req_in  = 1'b1;
        addr_in = 3'd5;
        cycle();
        idle();
        check("t3_underrun_set", underrun, 1'b1);
        flags_clr = 1'b1;
        cycle();
        idle();
        check("t3_underrun_clr", underrun, 1'b0);

        // 4: nine writes with no consumer, ninth dropped
        for (int i = 0; i < 9; i++) begin
            wa[i]    = 3'(i);
            wd[i]    = W'($urandom);
            out_en   = 1'b1;
            addr_out = wa[i];
            data_out = wd[i];
            cycle();
        end
        idle();
        check("t4_overflow", overflow, 1'b1);
        snk_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("t4_drain_addr", snk_addr, wa[i]);
            check("t4_drain_data", snk_data, wd[i]);
            cycle();
        end
        check("t4_empty", snk_valid, 1'b0);
        idle();
        flags_clr = 1'b1;
        cycle();
        idle();

        // 5: simultaneous push and pop on a full FIFO
        for (int i = 0; i < 8; i++) begin
            wa[i]    = 3'(7 - i);
            wd[i]    = W'($urandom);
            out_en   = 1'b1;
            addr_out = wa[i];
            data_out = wd[i];
            cycle();
        end
        new_d     = W'($urandom);
        out_en    = 1'b1;
        addr_out  = 3'd2;
        data_out  = new_d;
        snk_ready = 1'b1;
        cycle();
        idle();
        check("t5_overflow", overflow, 1'b0);
        snk_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check("t5_drain_data", snk_data, wd[i]);
            cycle();
        end
        check("t5_last_valid", snk_valid, 1'b1);
        check("t5_last_addr", snk_addr, 3'd2);
        check("t5_last_data", snk_data, new_d);
        cycle();
        check("t5_empty", snk_valid, 1'b0);
        idle();

`ifdef IOB_TSTAMP_EN
        // 6: timestamps of writes at cycles 10 and 13 after reset
        do_reset();
        for (int c = 0; c < 15; c++) begin
            out_en   = (c == 10) || (c == 13);
            addr_out = 3'd1;
            data_out = W'(c);
            cycle();
        end
        idle();
        t1 = snk_ts;
        check("t6_ts_first", t1, 16'd10);
        snk_ready = 1'b1;
        cycle();
        t2 = snk_ts;
        check("t6_ts_delta", 16'(t2 - t1), 16'd3);
        cycle();
        idle();
`endif

        // Randomized traffic against the model
        for (int n = 0; n < 500; n++) begin
            req_in    = ($urandom_range(0, 1) == 1);
            addr_in   = 3'($urandom_range(0, 7));
            out_en    = ($urandom_range(0, 2) != 0);
            addr_out  = 3'($urandom_range(0, 7));
            data_out  = W'($urandom);
            src_valid = 8'($urandom);
            for (int k = 0; k < NIN; k++) src_data[k*W +: W] = W'($urandom);
            snk_ready = ($urandom_range(0, 3) == 0);
            flags_clr = ($urandom_range(0, 15) == 0);
            cycle();
        end
        idle();
        for (int n = 0; n < 10; n++) begin
            snk_ready = 1'b1;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
